// File: rtl/pad_share_arbiter.sv
// pad_share_arbiter
// Shares one bidirectional pad cell between NumReq requesters. Ownership is
// granted round-robin and held until the owner drops its request; between
// owners the pad is released with its pull enabled for TurnCycles cycles in
// TURN plus at least one cycle in IDLE.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_i      synchronous active-high reset
//   req_i      per-requester ownership request (level)
//   oen_i      per-requester output enable (active-low), used for the owner
//   i_i        per-requester output data, used for the owner
//   gnt_o      registered one-hot-or-zero grant
//   o_o        pad input data routed to the owner, 0 elsewhere
//   owner_o    index of the current or last owner
//   busy_o     high in OWN or TURN
//   pad_oen_o  pad OEN
//   pad_i_o    pad I
//   pad_pen_o  pad PEN (0 = pull enabled)
//   pad_o_i    pad O
module pad_share_arbiter #(
  parameter int NumReq     = 4,
  parameter int TurnCycles = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumReq-1:0]         req_i,
  input  logic [NumReq-1:0]         oen_i,
  input  logic [NumReq-1:0]         i_i,
  output logic [NumReq-1:0]         gnt_o,
  output logic [NumReq-1:0]         o_o,
  output logic [$clog2(NumReq)-1:0] owner_o,
  output logic                      busy_o,
  output logic                      pad_oen_o,
  output logic                      pad_i_o,
  output logic                      pad_pen_o,
  input  logic                      pad_o_i
);

  localparam int IdxW = $clog2(NumReq);
  localparam int CntW = $clog2(TurnCycles + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  state_t            state;
  logic [IdxW-1:0]   owner;
  logic [IdxW-1:0]   ptr;
  logic [CntW-1:0]   cnt;
  logic [NumReq-1:0] gnt;

  logic              win_found;
  logic [IdxW-1:0]   win_idx;
  logic [IdxW-1:0]   ptr_next;
  logic [NumReq-1:0] win_onehot;

  // Round-robin search: first asserted request at or after ptr, wrapping.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NumReq; i++) begin
      idx = (int'(ptr) + i) % NumReq;
      if (!win_found && req_i[idx]) begin
        win_found = 1'b1;
        win_idx   = IdxW'(idx);
      end
    end
    win_onehot = '0;
    win_onehot[win_idx] = 1'b1;
    // NumReq need not be a power of two, so wrap explicitly.
    if (win_idx == IdxW'(NumReq - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
      gnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state <= OWN;
            owner <= win_idx;
            gnt   <= win_onehot;
            ptr   <= ptr_next;
          end
        end
        OWN: begin
          // Only the owner's own request matters here; others never preempt.
          if (!req_i[owner]) begin
            state <= TURN;
            gnt   <= '0;
            cnt   <= CntW'(TurnCycles);
          end
        end
        TURN: begin
          // Leaving on cnt==1 makes TURN last exactly TurnCycles cycles;
          // the counter lands on 0 as the block enters IDLE.
          if (cnt <= CntW'(1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

  // Pad controls follow the owner only in OWN; otherwise released with pull on.
  always_comb begin
    pad_oen_o = 1'b1;
    pad_i_o   = 1'b0;
    pad_pen_o = 1'b0;
    if (state == OWN) begin
      pad_oen_o = oen_i[owner];
      pad_i_o   = i_i[owner];
      pad_pen_o = 1'b1;
    end
  end

  assign gnt_o   = gnt;
  assign o_o     = gnt & {NumReq{pad_o_i}};
  assign owner_o = owner;
  assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_pad_share_arbiter.sv
module tb_pad_share_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] oen;
  logic [3:0] din;
  logic [3:0] gnt;
  logic [3:0] o;
  logic [1:0] owner;
  logic       busy;
  logic       pad_oen;
  logic       pad_i;
  logic       pad_pen;
  logic       pad_o;

  int total;
  int bad;

  pad_share_arbiter #(.NumReq(4), .TurnCycles(2)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .oen_i     (oen),
    .i_i       (din),
    .gnt_o     (gnt),
    .o_o       (o),
    .owner_o   (owner),
    .busy_o    (busy),
    .pad_oen_o (pad_oen),
    .pad_i_o   (pad_i),
    .pad_pen_o (pad_pen),
    .pad_o_i   (pad_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    req   = 4'($urandom);
    oen   = 4'($urandom);
    din   = 4'($urandom);
    pad_o = 1'($urandom);
    tick();
    req   = 4'($urandom);
    din   = 4'($urandom);
    tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    total++; if (o !== 4'b0000) begin bad++; $display("FAIL reset_o got=%b exp=0000", o); end
    total++; if (owner !== 2'd0) begin bad++; $display("FAIL reset_owner got=%0d exp=0", owner); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (pad_oen !== 1'b1) begin bad++; $display("FAIL reset_oen got=%b exp=1", pad_oen); end
    total++; if (pad_i !== 1'b0) begin bad++; $display("FAIL reset_pad_i got=%b exp=0", pad_i); end
    total++; if (pad_pen !== 1'b0) begin bad++; $display("FAIL reset_pen got=%b exp=0", pad_pen); end
    rst   = 1'b0;
    req   = 4'b0000;
    pad_o = 1'b0;
    oen   = 4'b1111;
    din   = 4'b0000;
    tick();
  endtask

  task automatic test_single_owner();
    do_reset();
    oen = 4'b1011;
    din = 4'b0000;
    req = 4'b0100;
    tick();
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
    total++; if (owner !== 2'd2) begin bad++; $display("FAIL single_owner got=%0d exp=2", owner); end
    total++; if (pad_pen !== 1'b1) begin bad++; $display("FAIL single_pen got=%b exp=1", pad_pen); end
    total++; if (pad_oen !== 1'b0) begin bad++; $display("FAIL single_oen got=%b exp=0", pad_oen); end
    total++; if (pad_i !== 1'b0) begin bad++; $display("FAIL single_pad_i0 got=%b exp=0", pad_i); end
    din = 4'b0100; #1;
    total++; if (pad_i !== 1'b1) begin bad++; $display("FAIL single_pad_i1 got=%b exp=1", pad_i); end
    din = 4'b1011; #1;
    total++; if (pad_i !== 1'b0) begin bad++; $display("FAIL single_pad_i_other got=%b exp=0", pad_i); end
    pad_o = 1'b1; #1;
    total++; if (o !== 4'b0100) begin bad++; $display("FAIL single_o1 got=%b exp=0100", o); end
    pad_o = 1'b0; #1;
    total++; if (o !== 4'b0000) begin bad++; $display("FAIL single_o0 got=%b exp=0000", o); end
    oen = 4'b1111; #1;
    total++; if (pad_oen !== 1'b1) begin bad++; $display("FAIL single_oen_toggle got=%b exp=1", pad_oen); end
    req = 4'b0000;
    tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL single_rel_gnt got=%b exp=0000", gnt); end
    total++; if (pad_pen !== 1'b0) begin bad++; $display("FAIL single_rel_pen got=%b exp=0", pad_pen); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_rel_busy got=%b exp=1", busy); end
    tick();
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_round_robin();
    int exp_own [4];
    logic [3:0] exp_gnt;
    exp_own = '{0, 1, 3, 0};
    do_reset();
    oen   = 4'b0000;
    pad_o = 1'b1;
    req   = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      exp_gnt = 4'b0000;
      exp_gnt[exp_own[k]] = 1'b1;
      for (int c = 0; c < 3; c++) begin
        tick();
        total++; if (gnt !== exp_gnt) begin bad++; $display("FAIL rr_gnt k=%0d c=%0d got=%b exp=%b", k, c, gnt, exp_gnt); end
      end
      total++; if (owner !== 2'(exp_own[k])) begin bad++; $display("FAIL rr_owner k=%0d got=%0d exp=%0d", k, owner, exp_own[k]); end
      total++; if (o !== exp_gnt) begin bad++; $display("FAIL rr_o k=%0d got=%b exp=%b", k, o, exp_gnt); end
      req[exp_own[k]] = 1'b0;
      tick();
      req = 4'b1011;
      total++; if (gnt !== 4'b0000 || busy !== 1'b1 || pad_oen !== 1'b1) begin bad++; $display("FAIL rr_turn1 k=%0d gnt=%b busy=%b oen=%b exp 0000/1/1", k, gnt, busy, pad_oen); end
      tick();
      total++; if (gnt !== 4'b0000 || busy !== 1'b1 || pad_pen !== 1'b0) begin bad++; $display("FAIL rr_turn2 k=%0d gnt=%b busy=%b pen=%b exp 0000/1/0", k, gnt, busy, pad_pen); end
      if (k == 3) req = 4'b0000;
      tick();
      total++; if (gnt !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL rr_idle k=%0d gnt=%b busy=%b exp 0000/0", k, gnt, busy); end
    end
    pad_o = 1'b0;
    oen   = 4'b1111;
  endtask

  task automatic test_no_preempt();
    do_reset();
    req = 4'b0010;
    tick();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL np_first got=%b exp=0010", gnt); end
    req = 4'b1011;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL np_hold c=%0d got=%b exp=0010", c, gnt); end
    end
    req = 4'b1001;
    tick();
    tick();
    tick();
    total++; if (gnt !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL np_idle gnt=%b busy=%b exp 0000/0", gnt, busy); end
    tick();
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL np_next_gnt got=%b exp=1000", gnt); end
    total++; if (owner !== 2'd3) begin bad++; $display("FAIL np_next_owner got=%0d exp=3", owner); end
    req = 4'b0000;
    tick();
    tick();
    tick();
  endtask

  task automatic test_withdraw();
    do_reset();
    req = 4'b0001;
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL wd_gnt got=%b exp=0001", gnt); end
    req = 4'b0000;
    tick();
    req = 4'b1000;
    tick();
    req = 4'b0000;
    total++; if (busy !== 1'b1 || gnt !== 4'b0000) begin bad++; $display("FAIL wd_turn busy=%b gnt=%b exp 1/0000", busy, gnt); end
    tick();
    total++; if (busy !== 1'b0 || gnt !== 4'b0000) begin bad++; $display("FAIL wd_idle busy=%b gnt=%b exp 0/0000", busy, gnt); end
    tick();
    tick();
    total++; if (busy !== 1'b0 || gnt !== 4'b0000) begin bad++; $display("FAIL wd_stay busy=%b gnt=%b exp 0/0000", busy, gnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    oen = 4'b0000;
    req = 4'b0010;
    tick();
    tick();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL rm_own got=%b exp=0010", gnt); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL rm_gnt got=%b exp=0000", gnt); end
    total++; if (pad_oen !== 1'b1 || pad_pen !== 1'b0) begin bad++; $display("FAIL rm_pad oen=%b pen=%b exp 1/0", pad_oen, pad_pen); end
    total++; if (busy !== 1'b0 || owner !== 2'd0) begin bad++; $display("FAIL rm_state busy=%b owner=%0d exp 0/0", busy, owner); end
    req = 4'b0110;
    tick();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL rm_regrant got=%b exp=0010", gnt); end
    total++; if (owner !== 2'd1) begin bad++; $display("FAIL rm_owner got=%0d exp=1", owner); end
    req = 4'b0000;
    oen = 4'b1111;
    tick();
    tick();
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    req   = 4'b0000;
    oen   = 4'b1111;
    din   = 4'b0000;
    pad_o = 1'b0;
    test_reset();
    test_single_owner();
    test_round_robin();
    test_no_preempt();
    test_withdraw();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
